usb2_link_state_ctrl: RTL and testbench

//  Device-side USB 2.0 link sequencer that drives the PHY's UTMI control inputs.
//  - Detects attach, bus reset, suspend and resume from UTMI linestate.
//  - Runs the high-speed detection (chirp) handshake and reverts from HS to FS.
//  - Sits between the protocol engine and the PHY top; one clock domain (48MHz ref).

---
 rtl/usb2_link_state_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_usb2_link_state_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/usb2_link_state_ctrl.sv
// Purpose: device-side USB 2.0 link sequencer (attach, bus reset, HS chirp, suspend/resume) driving UTMI controls.
// Latency: state and all UTMI/status outputs are registered, so outputs follow a line event after one clock.
// Backpressure: none, linestate is sampled every cycle. Define USB2_REMOTE_WAKEUP_EN to add remote wakeup (state 9).
module usb2_link_state_ctrl #(
  parameter int RST_SE0_CYC    = 120,
  parameter int SUSP_IDLE_CYC  = 144000,
  parameter int REVERT_CYC     = 9600,
  parameter int CHIRP_K_CYC    = 48000,
  parameter int CHIRP_WAIT_CYC = 96000,
  parameter int KJ_MIN_CYC     = 120,
  parameter int CNT_W          = 18
`ifdef USB2_REMOTE_WAKEUP_EN
  ,
  parameter int WAKE_MIN_CYC   = 240000,
  parameter int RWAKE_K_CYC    = 48000
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_connect,
  input  logic       i_hs_capable,
  input  logic [1:0] i_linestate,
  output logic [1:0] o_xcvrselect,
  output logic       o_termselect,
  output logic [1:0] o_opmode,
  output logic       o_suspendm,
  output logic       o_chirp_tx,
  output logic       o_bus_reset,
  output logic       o_hs_mode,
  output logic [3:0] o_state
`ifdef USB2_REMOTE_WAKEUP_EN
  ,
  input  logic       i_wakeup_req,
  output logic       o_resume_tx
`endif
);

  typedef enum logic [3:0] {
    ST_DETACHED   = 4'd0,
    ST_FS_IDLE    = 4'd1,
    ST_BUS_RESET  = 4'd2,
    ST_CHIRP_K    = 4'd3,
    ST_CHIRP_WAIT = 4'd4,
    ST_HS_IDLE    = 4'd5,
    ST_HS_REVERT  = 4'd6,
    ST_SUSPEND    = 4'd7,
    ST_RESUME     = 4'd8,
    ST_RWAKE      = 4'd9
  } state_t;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX         = '1;
  localparam logic [CNT_W-1:0] RST_SE0_N       = CNT_W'(RST_SE0_CYC);
  localparam logic [CNT_W-1:0] SUSP_IDLE_N     = CNT_W'(SUSP_IDLE_CYC);
  localparam logic [CNT_W-1:0] KJ_MIN_N        = CNT_W'(KJ_MIN_CYC);
  localparam logic [CNT_W-1:0] REVERT_LAST     = CNT_W'(REVERT_CYC - 1);
  localparam logic [CNT_W-1:0] CHIRP_K_LAST    = CNT_W'(CHIRP_K_CYC - 1);
  localparam logic [CNT_W-1:0] CHIRP_WAIT_LAST = CNT_W'(CHIRP_WAIT_CYC - 1);
`ifdef USB2_REMOTE_WAKEUP_EN
  localparam logic [CNT_W-1:0] WAKE_MIN_N      = CNT_W'(WAKE_MIN_CYC);
  localparam logic [CNT_W-1:0] RWAKE_LAST      = CNT_W'(RWAKE_K_CYC - 1);
`endif

  state_t           state, next_state;
  logic             state_chg;
  logic [1:0]       ls_q;        // linestate seen last cycle
  logic [CNT_W-1:0] run_cnt;     // length of the ls_q run up to last cycle, within this state
  logic [CNT_W-1:0] run_len;     // length of the current run including this cycle
  logic [CNT_W-1:0] phase;       // cycles since entering the current state (0 on first cycle)
  logic             got_k, got_k_d;
  logic [1:0]       pairs, pairs_d;
  logic             seen_se0, seen_se0_d;
  logic             hs_mode_d;
  logic [1:0]       xcvr_d, opmode_d;
  logic             term_d, susp_d, chirp_d, bus_reset_d;
`ifdef USB2_REMOTE_WAKEUP_EN
  logic             resume_d;
`endif

  assign state_chg = (next_state != state);
  assign o_state   = state;

  // Current run length: extends the stored run when the line holds, else starts at one.
  always_comb begin
    run_len = CNT_W'(1);
    if (i_linestate == ls_q) begin
      run_len = (run_cnt == CNT_MAX) ? CNT_MAX : run_cnt + CNT_W'(1);
    end
  end

  // Next-state decision, chirp pair tracking and HS-mode flag.
  always_comb begin
    next_state = state;
    hs_mode_d  = o_hs_mode;
    got_k_d    = got_k;
    pairs_d    = pairs;
    seen_se0_d = seen_se0;
    if (!i_connect) begin
      next_state = ST_DETACHED;
      hs_mode_d  = 1'b0;
    end else begin
      case (state)
        ST_DETACHED: next_state = ST_FS_IDLE;
        ST_FS_IDLE: begin
          if (i_linestate == LS_SE0 && run_len >= RST_SE0_N)
            next_state = ST_BUS_RESET;
          else if (i_linestate == LS_J && run_len >= SUSP_IDLE_N)
            next_state = ST_SUSPEND;
        end
        ST_BUS_RESET: begin
          if (i_hs_capable)
            next_state = ST_CHIRP_K;
          else if (i_linestate != LS_SE0)
            next_state = ST_FS_IDLE;
        end
        ST_CHIRP_K: begin
          if (phase == CHIRP_K_LAST)
            next_state = ST_CHIRP_WAIT;
        end
        ST_CHIRP_WAIT: begin
          // A host K or J run that ends short breaks the sequence.
          if (i_linestate != ls_q && (ls_q == LS_K || ls_q == LS_J) && run_cnt < KJ_MIN_N) begin
            got_k_d = 1'b0;
            pairs_d = 2'd0;
          end
          // K and J are credited the cycle their run reaches the minimum length.
          if (i_linestate == LS_K && run_len == KJ_MIN_N) begin
            got_k_d = 1'b1;
          end else if (i_linestate == LS_J && run_len == KJ_MIN_N && got_k_d) begin
            got_k_d = 1'b0;
            if (pairs_d == 2'd2) begin
              next_state = ST_HS_IDLE;
              hs_mode_d  = 1'b1;
            end else begin
              pairs_d = pairs_d + 2'd1;
            end
          end
          if (next_state == ST_CHIRP_WAIT && phase == CHIRP_WAIT_LAST)
            next_state = ST_FS_IDLE;
        end
        ST_HS_IDLE: begin
          if (i_linestate == LS_SE0 && run_len >= SUSP_IDLE_N)
            next_state = ST_HS_REVERT;
        end
        ST_HS_REVERT: begin
          if (phase == REVERT_LAST) begin
            if (i_linestate == LS_J)
              next_state = ST_SUSPEND;
            else if (i_linestate == LS_SE0)
              next_state = ST_BUS_RESET;
            else
              next_state = ST_HS_IDLE;
          end
        end
        ST_SUSPEND: begin
          if (i_linestate == LS_K)
            next_state = ST_RESUME;
          else if (i_linestate == LS_SE0 && run_len >= RST_SE0_N)
            next_state = ST_BUS_RESET;
`ifdef USB2_REMOTE_WAKEUP_EN
          else if (i_wakeup_req && phase >= WAKE_MIN_N)
            next_state = ST_RWAKE;
`endif
        end
        ST_RESUME: begin
          // Resume ends with the host EOP: SE0 followed by J.
          if (i_linestate == LS_SE0)
            seen_se0_d = 1'b1;
          else if (i_linestate == LS_J && seen_se0)
            next_state = o_hs_mode ? ST_HS_IDLE : ST_FS_IDLE;
        end
`ifdef USB2_REMOTE_WAKEUP_EN
        ST_RWAKE: begin
          if (phase == RWAKE_LAST)
            next_state = ST_RESUME;
        end
`endif
        default: next_state = ST_DETACHED;
      endcase
    end
    // Every bus reset drops back to full speed.
    if (next_state == ST_BUS_RESET)
      hs_mode_d = 1'b0;
  end

  // UTMI control decode for the state being entered, so outputs line up with o_state.
  always_comb begin
    xcvr_d      = 2'b01;
    term_d      = 1'b1;
    opmode_d    = 2'b00;
    susp_d      = 1'b1;
    chirp_d     = 1'b0;
    bus_reset_d = (next_state == ST_BUS_RESET) && (state != ST_BUS_RESET);
`ifdef USB2_REMOTE_WAKEUP_EN
    resume_d    = 1'b0;
`endif
    case (next_state)
      ST_DETACHED: begin
        term_d   = 1'b0;
        opmode_d = 2'b01;
      end
      ST_CHIRP_K: begin
        xcvr_d   = 2'b00;
        opmode_d = 2'b10;
        chirp_d  = 1'b1;
      end
      ST_CHIRP_WAIT: xcvr_d = 2'b00;
      ST_HS_IDLE: begin
        xcvr_d = 2'b00;
        term_d = 1'b0;
      end
      ST_SUSPEND: susp_d = 1'b0;
`ifdef USB2_REMOTE_WAKEUP_EN
      ST_RWAKE: begin
        opmode_d = 2'b10;
        resume_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State, counters, chirp tracking and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_DETACHED;
      ls_q         <= LS_SE0;
      run_cnt      <= '0;
      phase        <= '0;
      got_k        <= 1'b0;
      pairs        <= 2'd0;
      seen_se0     <= 1'b0;
      o_xcvrselect <= 2'b01;
      o_termselect <= 1'b0;
      o_opmode     <= 2'b01;
      o_suspendm   <= 1'b1;
      o_chirp_tx   <= 1'b0;
      o_bus_reset  <= 1'b0;
      o_hs_mode    <= 1'b0;
`ifdef USB2_REMOTE_WAKEUP_EN
      o_resume_tx  <= 1'b0;
`endif
    end else begin
      state        <= next_state;
      ls_q         <= i_linestate;
      run_cnt      <= state_chg ? '0 : run_len;
      phase        <= state_chg ? '0 : ((phase == CNT_MAX) ? phase : phase + CNT_W'(1));
      got_k        <= state_chg ? 1'b0 : got_k_d;
      pairs        <= state_chg ? 2'd0 : pairs_d;
      seen_se0     <= state_chg ? 1'b0 : seen_se0_d;
      o_xcvrselect <= xcvr_d;
      o_termselect <= term_d;
      o_opmode     <= opmode_d;
      o_suspendm   <= susp_d;
      o_chirp_tx   <= chirp_d;
      o_bus_reset  <= bus_reset_d;
      o_hs_mode    <= hs_mode_d;
`ifdef USB2_REMOTE_WAKEUP_EN
      o_resume_tx  <= resume_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb2_link_state_ctrl.sv
// Purpose: directed self-checking bench for usb2_link_state_ctrl with scaled timing parameters.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next edge.
// Backpressure: not applicable; every wait is a fixed cycle count or a bounded loop.
module tb_usb2_link_state_ctrl;

  logic       clk = 1'b0;
  logic       rst, connect, hs_capable;
  logic [1:0] linestate;
  logic [1:0] xcvrselect, opmode;
  logic       termselect, suspendm, chirp_tx, bus_reset, hs_mode;
  logic [3:0] state;
`ifdef USB2_REMOTE_WAKEUP_EN
  logic       wakeup_req;
  logic       resume_tx;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] LJ  = 2'b01;
  localparam logic [1:0] LK  = 2'b10;

  always #5 clk = ~clk;

  usb2_link_state_ctrl #(
    .RST_SE0_CYC(8), .SUSP_IDLE_CYC(40), .REVERT_CYC(10), .CHIRP_K_CYC(20),
    .CHIRP_WAIT_CYC(60), .KJ_MIN_CYC(4), .CNT_W(18)
`ifdef USB2_REMOTE_WAKEUP_EN
    , .WAKE_MIN_CYC(30), .RWAKE_K_CYC(12)
`endif
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_connect(connect), .i_hs_capable(hs_capable),
    .i_linestate(linestate), .o_xcvrselect(xcvrselect), .o_termselect(termselect),
    .o_opmode(opmode), .o_suspendm(suspendm), .o_chirp_tx(chirp_tx),
    .o_bus_reset(bus_reset), .o_hs_mode(hs_mode), .o_state(state)
`ifdef USB2_REMOTE_WAKEUP_EN
    , .i_wakeup_req(wakeup_req), .o_resume_tx(resume_tx)
`endif
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; connect = 1'b0; hs_capable = 1'b0; linestate = LJ;
`ifdef USB2_REMOTE_WAKEUP_EN
    wakeup_req = 1'b0;
`endif
    step(2);
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL rst_state: got %0d exp 0", state); end
    n_cmp++; if (xcvrselect !== 2'b01) begin n_err++; $display("FAIL rst_xcvr: got %b exp 01", xcvrselect); end
    n_cmp++; if (termselect !== 1'b0) begin n_err++; $display("FAIL rst_term: got %b exp 0", termselect); end
    n_cmp++; if (opmode !== 2'b01) begin n_err++; $display("FAIL rst_opmode: got %b exp 01", opmode); end
    n_cmp++; if (suspendm !== 1'b1) begin n_err++; $display("FAIL rst_suspendm: got %b exp 1", suspendm); end
    n_cmp++; if ({chirp_tx, bus_reset, hs_mode} !== 3'b000) begin n_err++; $display("FAIL rst_pulses: got %b exp 000", {chirp_tx, bus_reset, hs_mode}); end
    rst = 1'b0;
    step(3);
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL detached_hold: got %0d exp 0", state); end
    connect = 1'b1;
    step(1);
    n_cmp++; if (state !== 4'd1) begin n_err++; $display("FAIL attach_state: got %0d exp 1", state); end
    n_cmp++; if ({termselect, opmode} !== 3'b100) begin n_err++; $display("FAIL attach_term_op: got %b exp 100", {termselect, opmode}); end
  endtask

  task automatic test_fs_reset();
    hs_capable = 1'b0; linestate = SE0;
    step(7);
    n_cmp++; if (state !== 4'd1) begin n_err++; $display("FAIL fs_se0_7: got %0d exp 1", state); end
    step(1);
    n_cmp++; if (state !== 4'd2) begin n_err++; $display("FAIL fs_se0_8_state: got %0d exp 2", state); end
    n_cmp++; if (bus_reset !== 1'b1) begin n_err++; $display("FAIL fs_bus_reset_pulse: got %b exp 1", bus_reset); end
    step(1);
    n_cmp++; if ({state, bus_reset} !== {4'd2, 1'b0}) begin n_err++; $display("FAIL fs_reset_hold: got %0d/%b exp 2/0", state, bus_reset); end
    linestate = LJ;
    step(1);
    n_cmp++; if (state !== 4'd1) begin n_err++; $display("FAIL fs_back_idle: got %0d exp 1", state); end
    n_cmp++; if (xcvrselect !== 2'b01) begin n_err++; $display("FAIL fs_xcvr: got %b exp 01", xcvrselect); end
  endtask

  task automatic enter_chirp_wait(input string tag);
    int cnt;
    hs_capable = 1'b1; linestate = SE0;
    step(8);
    n_cmp++; if ({state, bus_reset} !== {4'd2, 1'b1}) begin n_err++; $display("FAIL %s_reset: got %0d/%b exp 2/1", tag, state, bus_reset); end
    step(1);
    n_cmp++; if ({state, chirp_tx, opmode, xcvrselect} !== {4'd3, 1'b1, 2'b10, 2'b00}) begin n_err++; $display("FAIL %s_chirp_entry: got %0d/%b/%b/%b exp 3/1/10/00", tag, state, chirp_tx, opmode, xcvrselect); end
    cnt = 1;
    for (int i = 0; i < 40 && state == 4'd3; i++) begin
      step(1);
      if (chirp_tx) cnt++;
    end
    n_cmp++; if (cnt !== 20) begin n_err++; $display("FAIL %s_chirp_len: got %0d exp 20", tag, cnt); end
    n_cmp++; if (state !== 4'd4) begin n_err++; $display("FAIL %s_chirp_wait: got %0d exp 4", tag, state); end
  endtask

  task automatic test_hs_chirp();
    enter_chirp_wait("hs");
    for (int p = 0; p < 3; p++) begin
      if (p == 2) begin
        n_cmp++; if ({state, hs_mode} !== {4'd4, 1'b0}) begin n_err++; $display("FAIL hs_two_pairs: got %0d/%b exp 4/0", state, hs_mode); end
      end
      linestate = LK; step(5);
      linestate = LJ; step(5);
    end
    n_cmp++; if (state !== 4'd5) begin n_err++; $display("FAIL hs_idle_state: got %0d exp 5", state); end
    n_cmp++; if ({hs_mode, termselect, xcvrselect} !== {1'b1, 1'b0, 2'b00}) begin n_err++; $display("FAIL hs_outputs: got %b/%b/%b exp 1/0/00", hs_mode, termselect, xcvrselect); end
  endtask

  task automatic test_hs_suspend();
    linestate = SE0;
    step(39);
    n_cmp++; if (state !== 4'd5) begin n_err++; $display("FAIL hs_idle_39: got %0d exp 5", state); end
    step(1);
    n_cmp++; if ({state, xcvrselect, termselect} !== {4'd6, 2'b01, 1'b1}) begin n_err++; $display("FAIL hs_revert: got %0d/%b/%b exp 6/01/1", state, xcvrselect, termselect); end
    linestate = LJ;
    step(9);
    n_cmp++; if (state !== 4'd6) begin n_err++; $display("FAIL revert_9: got %0d exp 6", state); end
    step(1);
    n_cmp++; if ({state, suspendm} !== {4'd7, 1'b0}) begin n_err++; $display("FAIL hs_suspend: got %0d/%b exp 7/0", state, suspendm); end
    linestate = LK;
    step(1);
    n_cmp++; if ({state, suspendm} !== {4'd8, 1'b1}) begin n_err++; $display("FAIL hs_resume: got %0d/%b exp 8/1", state, suspendm); end
    linestate = SE0;
    step(1);
    n_cmp++; if (state !== 4'd8) begin n_err++; $display("FAIL resume_eop: got %0d exp 8", state); end
    linestate = LJ;
    step(1);
    n_cmp++; if ({state, hs_mode, xcvrselect} !== {4'd5, 1'b1, 2'b00}) begin n_err++; $display("FAIL resume_to_hs: got %0d/%b/%b exp 5/1/00", state, hs_mode, xcvrselect); end
  endtask

  task automatic test_hs_revert_reset();
    linestate = SE0;
    step(40);
    n_cmp++; if (state !== 4'd6) begin n_err++; $display("FAIL hs_revert2: got %0d exp 6", state); end
    step(10);
    n_cmp++; if ({state, bus_reset, hs_mode} !== {4'd2, 1'b1, 1'b0}) begin n_err++; $display("FAIL revert_bus_reset: got %0d/%b/%b exp 2/1/0", state, bus_reset, hs_mode); end
  endtask

  task automatic test_disconnect_chirp();
    step(1);
    n_cmp++; if ({state, chirp_tx} !== {4'd3, 1'b1}) begin n_err++; $display("FAIL disc_chirp_entry: got %0d/%b exp 3/1", state, chirp_tx); end
    step(10);
    connect = 1'b0;
    step(1);
    n_cmp++; if ({state, chirp_tx, opmode} !== {4'd0, 1'b0, 2'b01}) begin n_err++; $display("FAIL disc_state: got %0d/%b/%b exp 0/0/01", state, chirp_tx, opmode); end
    n_cmp++; if ({bus_reset, hs_mode} !== 2'b00) begin n_err++; $display("FAIL disc_pulses: got %b exp 00", {bus_reset, hs_mode}); end
    connect = 1'b1; linestate = LJ;
    step(1);
    n_cmp++; if (state !== 4'd1) begin n_err++; $display("FAIL reattach: got %0d exp 1", state); end
  endtask

  task automatic test_chirp_timeout();
    enter_chirp_wait("to");
    linestate = LK; step(5); linestate = LJ; step(5);
    linestate = LK; step(3); linestate = LJ; step(5);
    linestate = LK; step(5); linestate = LJ; step(5);
    linestate = LK; step(5); linestate = LJ; step(5);
    n_cmp++; if ({state, hs_mode} !== {4'd4, 1'b0}) begin n_err++; $display("FAIL short_k_ignored: got %0d/%b exp 4/0", state, hs_mode); end
    linestate = SE0;
    step(21);
    n_cmp++; if (state !== 4'd4) begin n_err++; $display("FAIL timeout_59: got %0d exp 4", state); end
    step(1);
    n_cmp++; if ({state, hs_mode} !== {4'd1, 1'b0}) begin n_err++; $display("FAIL timeout_60: got %0d/%b exp 1/0", state, hs_mode); end
    linestate = LJ;
  endtask

`ifdef USB2_REMOTE_WAKEUP_EN
  task automatic test_remote_wakeup();
    int cnt;
    step(40);
    n_cmp++; if (state !== 4'd7) begin n_err++; $display("FAIL fs_suspend: got %0d exp 7", state); end
    step(10);
    wakeup_req = 1'b1; step(1); wakeup_req = 1'b0;
    n_cmp++; if ({state, resume_tx} !== {4'd7, 1'b0}) begin n_err++; $display("FAIL early_wakeup: got %0d/%b exp 7/0", state, resume_tx); end
    step(19);
    wakeup_req = 1'b1; step(1); wakeup_req = 1'b0;
    n_cmp++; if ({state, resume_tx, opmode} !== {4'd9, 1'b1, 2'b10}) begin n_err++; $display("FAIL rwake_entry: got %0d/%b/%b exp 9/1/10", state, resume_tx, opmode); end
    cnt = 1;
    for (int i = 0; i < 30 && state == 4'd9; i++) begin
      step(1);
      if (resume_tx) cnt++;
    end
    n_cmp++; if ({state, 32'(cnt)} !== {4'd8, 32'd12}) begin n_err++; $display("FAIL rwake_len: got %0d/%0d exp 8/12", state, cnt); end
    linestate = SE0; step(1); linestate = LJ; step(1);
    n_cmp++; if (state !== 4'd1) begin n_err++; $display("FAIL rwake_fs_idle: got %0d exp 1", state); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fs_reset();
    test_hs_chirp();
    test_hs_suspend();
    test_hs_revert_reset();
    test_disconnect_chirp();
    test_chirp_timeout();
`ifdef USB2_REMOTE_WAKEUP_EN
    test_remote_wakeup();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
